regfile_debug_port: RTL and testbench

//  Debug master for the 8x16 register file. It dumps a range of registers out on a

---
 rtl/regfile_dbg_pkg.sv | 33 +++
 rtl/regfile_debug_port.sv | 145 ++++++++++++++
 tb/tb_regfile_debug_port.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dbg_pkg.sv
// ============================================================================
// Module : regfile_dbg_pkg
// Brief  : Shared constants and state encoding for the register-file debug port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_dbg_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    localparam logic OP_DUMP = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DUMP_RD = 3'd1,
        ST_DUMP_TX = 3'd2,
        ST_LOAD    = 3'd3,
        ST_LOAD_WR = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // A zero count means a full sweep of the register file.
    function automatic logic [ADDR_W:0] words_for_count(input logic [ADDR_W:0] cnt);
        return (cnt == '0) ? (ADDR_W+1)'(NUM_REGS) : cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_debug_port.sv
// ============================================================================
// Module : regfile_debug_port
// Brief  : Debug master that dumps a register range to a stream or loads it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_debug_port
    import regfile_dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    output logic [ADDR_W-1:0] reg_read_addr,
    input  logic [DATA_W-1:0] reg_read_data,
    output logic              hold,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_rem_one = (ADDR_W+1)'(1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_remaining;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [DATA_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]   r_out_addr;
    logic                r_out_last;
    logic [ADDR_W-1:0]   r_wr_dest;
    logic [DATA_W-1:0]   r_wr_data;

    logic w_cmd_fire;
    logic w_out_fire;
    logic w_in_fire;

    assign w_cmd_fire = cmd_valid && (r_state == ST_IDLE);
    assign w_out_fire = out_ready && (r_state == ST_DUMP_TX);
    assign w_in_fire  = in_valid  && (r_state == ST_LOAD);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    w_next = (cmd_op == OP_LOAD) ? ST_LOAD : ST_DUMP_RD;
                end
            end
            ST_DUMP_RD: w_next = ST_DUMP_TX;
            ST_DUMP_TX: begin
                if (w_out_fire) begin
                    w_next = r_out_last ? ST_DONE : ST_DUMP_RD;
                end
            end
            ST_LOAD: begin
                if (w_in_fire) begin
                    w_next = ST_LOAD_WR;
                end
            end
            ST_LOAD_WR: w_next = (r_remaining == c_rem_one) ? ST_DONE : ST_LOAD;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_rd_addr   <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
            r_wr_dest   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_ptr       <= cmd_addr;
                        r_remaining <= words_for_count(cmd_count);
                    end
                end
                ST_DUMP_RD: begin
                    r_rd_addr  <= r_ptr;
                    r_out_data <= reg_read_data;
                    r_out_addr <= r_ptr;
                    r_out_last <= (r_remaining == c_rem_one);
                end
                ST_DUMP_TX: begin
                    if (w_out_fire) begin
                        r_ptr       <= r_ptr + c_ptr_one;
                        r_remaining <= r_remaining - c_rem_one;
                    end
                end
                ST_LOAD: begin
                    if (w_in_fire) begin
                        r_wr_dest <= r_ptr;
                        r_wr_data <= in_data;
                    end
                end
                ST_LOAD_WR: begin
                    r_ptr       <= r_ptr + c_ptr_one;
                    r_remaining <= r_remaining - c_rem_one;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready      = (r_state == ST_IDLE);
    assign hold           = (r_state != ST_IDLE);
    assign out_valid      = (r_state == ST_DUMP_TX);
    assign in_ready       = (r_state == ST_LOAD);
    assign reg_write_en   = (r_state == ST_LOAD_WR);
    assign done           = (r_state == ST_DONE);
    assign out_data       = r_out_data;
    assign out_addr       = r_out_addr;
    assign out_last       = r_out_last;
    assign reg_write_dest = r_wr_dest;
    assign reg_write_data = r_wr_data;
    // The read address follows ptr only while fetching, otherwise it holds.
    assign reg_read_addr  = (r_state == ST_DUMP_RD) ? r_ptr : r_rd_addr;

endmodule

`default_nettype wire

// File: tb/tb_regfile_debug_port.sv
// ============================================================================
// Module : tb_regfile_debug_port
// Brief  : Scoreboard bench for regfile_debug_port with a behavioural 8x16 regfile.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_debug_port;
    import regfile_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [2:0]  cmd_addr = '0;
    logic [3:0]  cmd_count = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [2:0]  out_addr;
    logic        out_last;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [2:0]  reg_read_addr;
    logic [15:0] reg_read_data;
    logic        hold;
    logic        done;

    regfile_debug_port u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_count(cmd_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data), .reg_read_addr(reg_read_addr),
        .reg_read_data(reg_read_data), .hold(hold), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural register file, power-up r0..r7 = 1..8, not affected by rst.
    logic [15:0] rf [0:7];
    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'(i + 1);
        forever begin
            @(posedge clk);
            if (reg_write_en) rf[reg_write_dest] <= reg_write_data;
        end
    end
    assign reg_read_data = rf[reg_read_addr];

    typedef struct packed { logic [15:0] d; logic [2:0] a; logic l; } oexp_t;
    typedef struct packed { logic [2:0] a; logic [15:0] d; } wexp_t;

    oexp_t       out_q[$];
    wexp_t       wr_q[$];
    logic [15:0] ld_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cyc = -100;
    int n_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboards, stall stability, done timing, accept counting.
    bit    stall_prev = 1'b0;
    oexp_t stall_val;
    bit    expect_done = 1'b0;
    oexp_t oe;
    wexp_t we;
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && stall_prev) begin
                chk("stall_data", {16'h0, out_data}, {16'h0, stall_val.d});
                chk("stall_addr", {29'h0, out_addr}, {29'h0, stall_val.a});
                chk("stall_last", {31'h0, out_last}, {31'h0, stall_val.l});
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = '{d: out_data, a: out_addr, l: out_last};
            if (expect_done) begin
                chk("done_after_last", {31'h0, done}, 32'h1);
                expect_done = 1'b0;
            end
            if (done) done_cyc = cyc;
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    chk("out_unexpected", 32'h1, 32'h0);
                end else begin
                    oe = out_q.pop_front();
                    chk("out_data", {16'h0, out_data}, {16'h0, oe.d});
                    chk("out_addr", {29'h0, out_addr}, {29'h0, oe.a});
                    chk("out_last", {31'h0, out_last}, {31'h0, oe.l});
                    if (out_last) expect_done = 1'b1;
                end
            end
            if (reg_write_en) begin
                if (wr_q.size() == 0) begin
                    chk("write_unexpected", 32'h1, 32'h0);
                end else begin
                    we = wr_q.pop_front();
                    chk("wr_dest", {29'h0, reg_write_dest}, {29'h0, we.a});
                    chk("wr_data", {16'h0, reg_write_data}, {16'h0, we.d});
                end
            end
            if (cmd_valid && cmd_ready) n_acc++;
        end else begin
            stall_prev  = 1'b0;
            expect_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic op, input logic [2:0] a, input logic [3:0] c,
                             input bit keep);
        bit acc = 1'b0;
        cmd_op = op; cmd_addr = a; cmd_count = c; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) acc = 1'b1;
            tick();
        end
        if (!keep) cmd_valid = 1'b0;
        chk("cmd_accept", {31'h0, acc}, 32'h1);
    endtask

    task automatic wait_done(input bit toggle);
        bit seen = 1'b0;
        bit consume;
        in_valid = (ld_q.size() > 0);
        if (in_valid) in_data = ld_q[0];
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            chk("hold_busy", {31'h0, hold}, 32'h1);
            seen    = done;
            consume = in_valid && in_ready;
            tick();
            if (consume) void'(ld_q.pop_front());
            in_valid = (ld_q.size() > 0);
            if (in_valid) in_data = ld_q[0];
            if (toggle) out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        chk("done_seen", {31'h0, seen}, 32'h1);
    endtask

    task automatic chk_drained(input string name);
        chk(name, out_q.size() + wr_q.size(), 0);
    endtask

    task automatic chk_reset_outputs();
        @(negedge clk);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_hold",      {31'h0, hold}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_in_ready",  {31'h0, in_ready}, 32'h0);
        chk("rst_wr_en",     {31'h0, reg_write_en}, 32'h0);
        chk("rst_done",      {31'h0, done}, 32'h0);
        chk("rst_out_data",  {16'h0, out_data}, 32'h0);
        chk("rst_out_addr",  {29'h0, out_addr}, 32'h0);
        chk("rst_out_last",  {31'h0, out_last}, 32'h0);
        chk("rst_wr_dest",   {29'h0, reg_write_dest}, 32'h0);
        chk("rst_wr_data",   {16'h0, reg_write_data}, 32'h0);
        chk("rst_rd_addr",   {29'h0, reg_read_addr}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int acc_cyc;
        int acc_base;
        bit got;

        // Reset state
        tick(); tick();
        chk_reset_outputs();
        tick();
        rst = 1'b1;

        // 1: full sweep, count 0 means 8 words
        out_q.push_back('{d: 16'h0001, a: 3'd0, l: 1'b0});
        out_q.push_back('{d: 16'h0002, a: 3'd1, l: 1'b0});
        out_q.push_back('{d: 16'h0003, a: 3'd2, l: 1'b0});
        out_q.push_back('{d: 16'h0004, a: 3'd3, l: 1'b0});
        out_q.push_back('{d: 16'h0005, a: 3'd4, l: 1'b0});
        out_q.push_back('{d: 16'h0006, a: 3'd5, l: 1'b0});
        out_q.push_back('{d: 16'h0007, a: 3'd6, l: 1'b0});
        out_q.push_back('{d: 16'h0008, a: 3'd7, l: 1'b1});
        issue_cmd(OP_DUMP, 3'd0, 4'd0, 1'b0);
        wait_done(1'b0);
        chk_drained("t1_drained");

        // 2: wrapping dump with a stalling sink
        out_q.push_back('{d: 16'h0007, a: 3'd6, l: 1'b0});
        out_q.push_back('{d: 16'h0008, a: 3'd7, l: 1'b0});
        out_q.push_back('{d: 16'h0001, a: 3'd0, l: 1'b1});
        issue_cmd(OP_DUMP, 3'd6, 4'd3, 1'b0);
        wait_done(1'b1);
        chk_drained("t2_drained");

        // 3: load two words then read them back
        wr_q.push_back('{a: 3'd2, d: 16'hBEEF});
        wr_q.push_back('{a: 3'd3, d: 16'hCAFE});
        ld_q.push_back(16'hBEEF);
        ld_q.push_back(16'hCAFE);
        issue_cmd(OP_LOAD, 3'd2, 4'd2, 1'b0);
        wait_done(1'b0);
        chk_drained("t3_load_drained");
        out_q.push_back('{d: 16'hBEEF, a: 3'd2, l: 1'b0});
        out_q.push_back('{d: 16'hCAFE, a: 3'd3, l: 1'b1});
        issue_cmd(OP_DUMP, 3'd2, 4'd2, 1'b0);
        wait_done(1'b0);
        chk_drained("t3_dump_drained");

        // 4: command held valid across a busy dump
        acc_base = n_acc;
        out_q.push_back('{d: 16'h0001, a: 3'd0, l: 1'b0});
        out_q.push_back('{d: 16'h0002, a: 3'd1, l: 1'b1});
        out_q.push_back('{d: 16'h0005, a: 3'd4, l: 1'b1});
        issue_cmd(OP_DUMP, 3'd0, 4'd2, 1'b1);
        cmd_addr = 3'd4; cmd_count = 4'd1;
        acc = 1'b0; acc_cyc = -1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) begin acc = 1'b1; acc_cyc = cyc; end
            tick();
        end
        cmd_valid = 1'b0;
        chk("t4_accept_after_done", acc_cyc, done_cyc + 1);
        wait_done(1'b0);
        chk("t4_accept_count", n_acc - acc_base, 2);
        chk_drained("t4_drained");

        // 5: reset in the middle of a load
        wr_q.push_back('{a: 3'd5, d: 16'h1111});
        issue_cmd(OP_LOAD, 3'd5, 4'd3, 1'b0);
        in_valid = 1'b1; in_data = 16'h1111;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("t5_word_accepted", {31'h0, got}, 32'h1);
        @(negedge clk);
        chk("t5_write_pulse", {31'h0, reg_write_en}, 32'h1);
        tick();
        rst = 1'b0;
        tick();
        chk_reset_outputs();
        tick();
        @(negedge clk);
        chk("t5_no_write_in_rst", {31'h0, reg_write_en}, 32'h0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ready_after_rst", {31'h0, cmd_ready}, 32'h1);
        chk("t5_no_write_after", {31'h0, reg_write_en}, 32'h0);
        tick();
        out_q.push_back('{d: 16'h1111, a: 3'd5, l: 1'b0});
        out_q.push_back('{d: 16'h0007, a: 3'd6, l: 1'b1});
        issue_cmd(OP_DUMP, 3'd5, 4'd2, 1'b0);
        wait_done(1'b0);
        chk_drained("t5_drained");

        // 6: load wrapping r7 -> r0
        wr_q.push_back('{a: 3'd7, d: 16'hAAAA});
        wr_q.push_back('{a: 3'd0, d: 16'h5555});
        ld_q.push_back(16'hAAAA);
        ld_q.push_back(16'h5555);
        issue_cmd(OP_LOAD, 3'd7, 4'd2, 1'b0);
        wait_done(1'b0);
        out_q.push_back('{d: 16'hAAAA, a: 3'd7, l: 1'b0});
        out_q.push_back('{d: 16'h5555, a: 3'd0, l: 1'b1});
        issue_cmd(OP_DUMP, 3'd7, 4'd2, 1'b0);
        wait_done(1'b0);
        @(negedge clk);
        chk("t6_idle_hold", {31'h0, hold}, 32'h0);
        chk_drained("t6_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
